decode_stage: RTL and testbench

Pipelined SimpleRISC instruction decode stage. Accepts fetched instruction words with a valid/ready handshake and decodes each one. Each decode produces the one-hot ALU control vector, the I bit and the extended immediate consumed by the ALU, plus register indices and branch/writeback controls. The results are held in a two-entry skid buffer, so upstream ready depends only on registered state. The stage sits between fetch and the register-read/execute stage.

---
 rtl/simple_risc_pkg.sv | 61 ++++++
 rtl/decode_logic.sv | 32 +++
 rtl/decode_stage.sv | 87 ++++++++
 tb/tb_decode_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/simple_risc_pkg.sv
// simple_risc_pkg: SimpleRISC opcodes, aluSignals bit indices, immediate modifiers and decoded bundle
package simple_risc_pkg;
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_DIV = 3;
  localparam int ALU_MOD = 4;
  localparam int ALU_CMP = 5;
  localparam int ALU_AND = 6;
  localparam int ALU_OR  = 7;
  localparam int ALU_NOT = 8;
  localparam int ALU_MOV = 9;
  localparam int ALU_LSL = 10;
  localparam int ALU_LSR = 11;
  localparam int ALU_ASR = 12;
  localparam int ALU_LD  = 13;
  localparam int ALU_ST  = 14;
  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HIGH = 2'b10;
  localparam logic [1:0] MOD_BAD  = 2'b11;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [14:0] alu_signals;
    logic        is_immediate;
    logic [31:0] immx;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        wb_en;
    logic        is_beq;
    logic        is_bgt;
    logic        is_ubranch;
    logic        is_call;
    logic        is_ret;
    logic [31:0] branch_target;
    logic        illegal;
  } decoded_t;
endpackage

// File: rtl/decode_logic.sv
// decode_logic: combinational SimpleRISC decode of (instr, pc) into decoded_t
import simple_risc_pkg::*;
module decode_logic (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output decoded_t    dec
);
  logic [4:0]  op;
  logic [1:0]  mod;
  logic [15:0] imm;
  assign op  = instr[31:27];
  assign mod = instr[17:16];
  assign imm = instr[15:0];
  always_comb begin
    dec               = '0;
    dec.pc            = pc;
    dec.is_immediate  = instr[26];
    dec.immx          = mod == MOD_ZEXT ? {16'h0, imm} : mod == MOD_HIGH ? {imm, 16'h0} : {{16{imm[15]}}, imm};
    dec.rd            = op == OP_CALL ? 4'd15 : instr[25:22];
    dec.rs1           = op == OP_RET ? 4'd15 : instr[21:18];
    dec.rs2           = op == OP_ST ? instr[25:22] : instr[17:14];
    dec.alu_signals   = op <= OP_ASR ? 15'b1 << op : op == OP_LD ? 15'b1 << ALU_LD : op == OP_ST ? 15'b1 << ALU_ST : 15'b0;
    dec.wb_en         = (op <= OP_ASR && op != OP_CMP) || op == OP_LD || op == OP_CALL;
    dec.is_beq        = op == OP_BEQ;
    dec.is_bgt        = op == OP_BGT;
    dec.is_ubranch    = op == OP_B;
    dec.is_call       = op == OP_CALL;
    dec.is_ret        = op == OP_RET;
    dec.branch_target = pc + {{3{instr[26]}}, instr[26:0], 2'b00};
    dec.illegal       = op > OP_RET || mod == MOD_BAD;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: SimpleRISC decode with a two-entry skid buffer between fetch and execute
import simple_risc_pkg::*;
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [14:0] out_alu_signals,
  output logic        out_is_immediate,
  output logic [31:0] out_immx,
  output logic [3:0]  out_rd,
  output logic [3:0]  out_rs1,
  output logic [3:0]  out_rs2,
  output logic        out_wb_en,
  output logic        out_is_beq,
  output logic        out_is_bgt,
  output logic        out_is_ubranch,
  output logic        out_is_call,
  output logic        out_is_ret,
  output logic [31:0] out_branch_target,
  output logic        out_illegal
);
  buf_state_e state_q, state_d;
  decoded_t   dec, e0_q, e0_d, e1_q, e1_d;
  logic       push, pop;
  decode_logic u_decode (.instr(in_instr), .pc(in_pc), .dec(dec));
  assign in_ready  = state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  // e0 is always the head; e1 only holds the younger entry while in TWO
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        e0_d    = dec;
      end
      ONE: if (push && pop) e0_d = dec;
      else if (push) begin
        state_d = TWO;
        e1_d    = dec;
      end
      else if (pop) state_d = EMPTY;
      TWO: if (pop) begin
        state_d = ONE;
        e0_d    = e1_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end
  assign out_pc            = e0_q.pc;
  assign out_alu_signals   = e0_q.alu_signals;
  assign out_is_immediate  = e0_q.is_immediate;
  assign out_immx          = e0_q.immx;
  assign out_rd            = e0_q.rd;
  assign out_rs1           = e0_q.rs1;
  assign out_rs2           = e0_q.rs2;
  assign out_wb_en         = e0_q.wb_en;
  assign out_is_beq        = e0_q.is_beq;
  assign out_is_bgt        = e0_q.is_bgt;
  assign out_is_ubranch    = e0_q.is_ubranch;
  assign out_is_call       = e0_q.is_call;
  assign out_is_ret        = e0_q.is_ret;
  assign out_branch_target = e0_q.branch_target;
  assign out_illegal       = e0_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_pc;
  logic [14:0] out_alu_signals;
  logic        out_is_immediate;
  logic [31:0] out_immx;
  logic [3:0]  out_rd, out_rs1, out_rs2;
  logic        out_wb_en, out_is_beq, out_is_bgt, out_is_ubranch, out_is_call, out_is_ret;
  logic [31:0] out_branch_target;
  logic        out_illegal;
  int          checks = 0;
  int          errors = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_signals(out_alu_signals), .out_is_immediate(out_is_immediate), .out_immx(out_immx),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_wb_en(out_wb_en),
    .out_is_beq(out_is_beq), .out_is_bgt(out_is_bgt), .out_is_ubranch(out_is_ubranch),
    .out_is_call(out_is_call), .out_is_ret(out_is_ret), .out_branch_target(out_branch_target),
    .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 0;
  endtask
  initial begin
    step();
    step();
    rst = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu", 32'(out_alu_signals), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_immx", out_immx, 32'd0);
    out_ready = 1;
    send(32'h0048C000, 32'h0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_alu", 32'(out_alu_signals), 32'h0001);
    chk("add_rd", 32'(out_rd), 32'd1);
    chk("add_rs1", 32'(out_rs1), 32'd2);
    chk("add_rs2", 32'(out_rs2), 32'd3);
    chk("add_wb", 32'(out_wb_en), 32'd1);
    chk("add_imm_bit", 32'(out_is_immediate), 32'd0);
    chk("add_illegal", 32'(out_illegal), 32'd0);
    send(32'h4D00FFFF, 32'h4);
    chk("mov_sext_immx", out_immx, 32'hFFFFFFFF);
    chk("mov_sext_alu", 32'(out_alu_signals), 32'h0200);
    chk("mov_sext_ibit", 32'(out_is_immediate), 32'd1);
    chk("mov_rd", 32'(out_rd), 32'd4);
    send(32'h4D01FFFF, 32'h8);
    chk("mov_zext_immx", out_immx, 32'h0000FFFF);
    chk("mov_zext_alu", 32'(out_alu_signals), 32'h0200);
    chk("mov_zext_ibit", 32'(out_is_immediate), 32'd1);
    send(32'h4D02FFFF, 32'hC);
    chk("mov_high_immx", out_immx, 32'hFFFF0000);
    chk("mov_high_alu", 32'(out_alu_signals), 32'h0200);
    chk("mov_high_ibit", 32'(out_is_immediate), 32'd1);
    send(32'h4D03FFFF, 32'h10);
    chk("mod11_illegal", 32'(out_illegal), 32'd1);
    chk("mod11_immx", out_immx, 32'hFFFFFFFF);
    send(32'h70000000, 32'h14);
    chk("ld_alu", 32'(out_alu_signals), 32'h2000);
    chk("ld_wb", 32'(out_wb_en), 32'd1);
    send(32'h79400000, 32'h18);
    chk("st_alu", 32'(out_alu_signals), 32'h4000);
    chk("st_wb", 32'(out_wb_en), 32'd0);
    chk("st_rs2", 32'(out_rs2), 32'd5);
    send(32'h97FFFFFF, 32'h100);
    chk("b_ubranch", 32'(out_is_ubranch), 32'd1);
    chk("b_target", out_branch_target, 32'h000000FC);
    chk("b_alu", 32'(out_alu_signals), 32'd0);
    chk("b_wb", 32'(out_wb_en), 32'd0);
    send(32'h98000000, 32'h200);
    chk("call_flag", 32'(out_is_call), 32'd1);
    chk("call_rd", 32'(out_rd), 32'd15);
    chk("call_wb", 32'(out_wb_en), 32'd1);
    send(32'hA0000000, 32'h204);
    chk("ret_flag", 32'(out_is_ret), 32'd1);
    chk("ret_rs1", 32'(out_rs1), 32'd15);
    chk("ret_wb", 32'(out_wb_en), 32'd0);
    send(32'h80000000, 32'h208);
    chk("beq_flag", 32'(out_is_beq), 32'd1);
    send(32'h28000000, 32'h20C);
    chk("cmp_wb", 32'(out_wb_en), 32'd0);
    chk("cmp_alu", 32'(out_alu_signals), 32'h0020);
    send(32'hF8000000, 32'h210);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_alu", 32'(out_alu_signals), 32'd0);
    chk("ill_wb", 32'(out_wb_en), 32'd0);
    chk("ill_branch", 32'({out_is_beq, out_is_bgt, out_is_ubranch, out_is_call, out_is_ret}), 32'd0);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 0;
    send(32'h0048C000, 32'h10);
    chk("bp_a_head", out_pc, 32'h10);
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    send(32'h08000000, 32'h14);
    chk("bp_ready_two", 32'(in_ready), 32'd0);
    in_valid = 1;
    in_instr = 32'h4D00FFFF;
    in_pc    = 32'h18;
    step();
    chk("bp_c_waits", 32'(in_ready), 32'd0);
    chk("bp_head_stable", out_pc, 32'h10);
    chk("bp_head_alu", 32'(out_alu_signals), 32'h0001);
    out_ready = 1;
    step();
    chk("bp_b_pc", out_pc, 32'h14);
    chk("bp_b_alu", 32'(out_alu_signals), 32'h0002);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 0;
    chk("bp_c_pc", out_pc, 32'h18);
    chk("bp_c_alu", 32'(out_alu_signals), 32'h0200);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 0;
    send(32'h0048C000, 32'h20);
    send(32'h08000000, 32'h24);
    flush    = 1;
    in_valid = 1;
    in_instr = 32'h4D00FFFF;
    in_pc    = 32'h28;
    step();
    flush    = 0;
    in_valid = 0;
    chk("flush2_valid", 32'(out_valid), 32'd0);
    chk("flush2_ready", 32'(in_ready), 32'd1);
    step();
    chk("flush2_dropped", 32'(out_valid), 32'd0);
    send(32'h0048C000, 32'h30);
    flush    = 1;
    in_valid = 1;
    in_instr = 32'h08000000;
    in_pc    = 32'h34;
    step();
    flush    = 0;
    in_valid = 0;
    chk("flush1_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush1_dropped", 32'(out_valid), 32'd0);
    send(32'h0048C000, 32'h40);
    send(32'h08000000, 32'h44);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_pc", out_pc, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
